// File: rtl/regfile_mp_sb_pkg.sv
// regfile_mp_sb_pkg: shared defaults, constants and types for the register file slice
package regfile_mp_sb_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF = $clog2(NREGS_DEF);
  localparam int REG_ZERO = 0;
  typedef logic [AW_DEF-1:0] reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xdata_t;
endpackage

// File: rtl/regfile_mp_sb_wr_arb.sv
// regfile_mp_sb_wr_arb: per-register write hit and winning port, highest port index wins
module regfile_mp_sb_wr_arb
  import regfile_mp_sb_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NWR = 2,
  parameter int AW = $clog2(NREGS),
  parameter int SW = (NWR > 1) ? $clog2(NWR) : 1
) (
  input  logic [NWR-1:0]            we_i,
  input  logic [NWR-1:0][AW-1:0]    waddr_i,
  output logic [NREGS-1:0]          clr_o,
  output logic [NREGS-1:0][SW-1:0]  sel_o
);
  // ascending scan so a later (higher) port overwrites the selection of an earlier one
  always_comb begin
    clr_o = '0;
    sel_o = '0;
    for (int p = 0; p < NWR; p++) begin
      if (we_i[p]) begin
        clr_o[waddr_i[p]] = 1'b1;
        sel_o[waddr_i[p]] = SW'(p);
      end
    end
  end
endmodule

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with write bypass, busy scoreboard and debug port
module regfile_mp_sb
  import regfile_mp_sb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD = 2,
  parameter int NWR = 2,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NRD-1:0][AW-1:0]     raddr_i,
  output logic [NRD-1:0][XLEN-1:0]   rdata_o,
  output logic [NRD-1:0]             rbusy_o,
  input  logic [NWR-1:0]             we_i,
  input  logic [NWR-1:0][AW-1:0]     waddr_i,
  input  logic [NWR-1:0][XLEN-1:0]   wdata_i,
  input  logic                       iss_valid_i,
  input  logic [AW-1:0]              iss_rd_i,
  input  logic [AW-1:0]              dbg_addr_i,
  output logic [XLEN-1:0]            dbg_data_o
);
  localparam int SW = (NWR > 1) ? $clog2(NWR) : 1;
  localparam logic [AW-1:0] ZERO_A = AW'(REG_ZERO);
  logic [NREGS-1:0]          clr;
  logic [NREGS-1:0][SW-1:0]  sel;
  logic [NREGS-1:0]          set;
  logic [NREGS-1:0]          busy_q, busy_d;
  logic [XLEN-1:0]           mem_q [NREGS];

  regfile_mp_sb_wr_arb #(.NREGS(NREGS), .NWR(NWR), .AW(AW), .SW(SW)) u_arb (
    .we_i   (we_i),
    .waddr_i(waddr_i),
    .clr_o  (clr),
    .sel_o  (sel)
  );

  // a new producer claims the register even when a writeback retires the old one this edge
  always_comb begin
    set = (iss_valid_i && iss_rd_i != ZERO_A) ? (NREGS'(1) << iss_rd_i) : '0;
    busy_d = ((busy_q & ~clr) | set) & ~(NREGS'(1) << REG_ZERO);
  end

  // array and scoreboard state; register zero is never written so it stays at reset value 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      for (int r = 0; r < NREGS; r++) mem_q[r] <= '0;
    end else begin
      busy_q <= busy_d;
      for (int r = 1; r < NREGS; r++) if (clr[r]) mem_q[r] <= wdata_i[sel[r]];
    end
  end

  // reads bypass from the winning write port, and a same-cycle writeback hides the hazard
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rdata_o[i] = (raddr_i[i] == ZERO_A) ? '0
                 : clr[raddr_i[i]] ? wdata_i[sel[raddr_i[i]]] : mem_q[raddr_i[i]];
      rbusy_o[i] = busy_q[raddr_i[i]] & ~clr[raddr_i[i]] & (raddr_i[i] != ZERO_A);
    end
  end

  assign dbg_data_o = mem_q[dbg_addr_i];
endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: directed and randomized checks of regfile_mp_sb against a behavioural model
module tb_regfile_mp_sb;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int NRD = 2;
  localparam int NWR = 2;
  localparam int AW = 5;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [NRD-1:0][AW-1:0]    raddr = '0;
  logic [NRD-1:0][XLEN-1:0]  rdata;
  logic [NRD-1:0]            rbusy;
  logic [NWR-1:0]            we = '0;
  logic [NWR-1:0][AW-1:0]    waddr = '0;
  logic [NWR-1:0][XLEN-1:0]  wdata = '0;
  logic                      iss_valid = 1'b0;
  logic [AW-1:0]             iss_rd = '0;
  logic [AW-1:0]             dbg_addr = '0;
  logic [XLEN-1:0]           dbg_data;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  logic [XLEN-1:0] m_mem [NREGS];
  bit              m_busy [NREGS];

  regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .raddr_i    (raddr),
    .rdata_o    (rdata),
    .rbusy_o    (rbusy),
    .we_i       (we),
    .waddr_i    (waddr),
    .wdata_i    (wdata),
    .iss_valid_i(iss_valid),
    .iss_rd_i   (iss_rd),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic bit wr_hit(input int a);
    for (int p = 0; p < NWR; p++) if (we[p] && int'(waddr[p]) == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [XLEN-1:0] exp_read(input int a);
    logic [XLEN-1:0] v;
    if (a == 0) return '0;
    v = m_mem[a];
    for (int p = 0; p < NWR; p++) if (we[p] && int'(waddr[p]) == a) v = wdata[p];
    return v;
  endfunction

  function automatic bit exp_busy(input int a);
    return a != 0 && m_busy[a] && !wr_hit(a);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        m_mem[r] = '0;
        m_busy[r] = 1'b0;
      end
    end else begin
      bit nb [NREGS];
      for (int r = 0; r < NREGS; r++) begin
        nb[r] = (m_busy[r] && !wr_hit(r)) || (iss_valid && int'(iss_rd) == r && r != 0);
      end
      for (int p = 0; p < NWR; p++) if (we[p] && waddr[p] != 0) m_mem[waddr[p]] = wdata[p];
      for (int r = 0; r < NREGS; r++) m_busy[r] = nb[r];
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      for (int i = 0; i < NRD; i++) begin
        chk($sformatf("model rdata[%0d]", i), rdata[i], exp_read(int'(raddr[i])));
        chk($sformatf("model rbusy[%0d]", i), XLEN'(rbusy[i]), XLEN'(exp_busy(int'(raddr[i]))));
      end
      chk("model dbg_data", dbg_data, m_mem[dbg_addr]);
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
    we = '0;
    iss_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    we[0] = 1'b1; waddr[0] = 5; wdata[0] = 32'hDEADBEEF;
    step();
    dbg_addr = 5; raddr[0] = 5;
    @(negedge clk);
    chk("pre-reset dbg x5", dbg_data, 32'hDEADBEEF);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset rdata x5", rdata[0], 32'h0);
    chk("reset rbusy x5", XLEN'(rbusy[0]), 32'h0);
    chk("reset dbg x5", dbg_data, 32'h0);
    we[0] = 1'b1; waddr[0] = 0; wdata[0] = 32'h1234; iss_valid = 1'b1; iss_rd = 0;
    step();
    raddr[0] = 0; dbg_addr = 0;
    @(negedge clk);
    chk("x0 rdata", rdata[0], 32'h0);
    chk("x0 rbusy", XLEN'(rbusy[0]), 32'h0);
    chk("x0 dbg", dbg_data, 32'h0);
    step();
    we[1] = 1'b1; waddr[1] = 7; wdata[1] = 32'hA5A5A5A5; raddr[0] = 7; dbg_addr = 7;
    @(negedge clk);
    chk("bypass rdata x7", rdata[0], 32'hA5A5A5A5);
    chk("bypass dbg old x7", dbg_data, 32'h0);
    step();
    @(negedge clk);
    chk("array dbg x7", dbg_data, 32'hA5A5A5A5);
    we = 2'b11; waddr[0] = 9; waddr[1] = 9; wdata[0] = 32'h11; wdata[1] = 32'h22; raddr[1] = 9;
    @(negedge clk);
    chk("priority bypass x9", rdata[1], 32'h22);
    step();
    dbg_addr = 9;
    @(negedge clk);
    chk("priority array x9", dbg_data, 32'h22);
    iss_valid = 1'b1; iss_rd = 12;
    step();
    raddr[0] = 12;
    @(negedge clk);
    chk("sb busy x12", XLEN'(rbusy[0]), 32'h1);
    step();
    we[0] = 1'b1; waddr[0] = 12; wdata[0] = 32'hCAFE;
    @(negedge clk);
    chk("sb wb rbusy x12", XLEN'(rbusy[0]), 32'h0);
    chk("sb wb rdata x12", rdata[0], 32'hCAFE);
    step();
    @(negedge clk);
    chk("sb after wb x12", XLEN'(rbusy[0]), 32'h0);
    iss_valid = 1'b1; iss_rd = 3;
    step();
    raddr[0] = 3;
    @(negedge clk);
    chk("coll busy x3", XLEN'(rbusy[0]), 32'h1);
    step();
    we[0] = 1'b1; waddr[0] = 3; wdata[0] = 32'h33; iss_valid = 1'b1; iss_rd = 3;
    step();
    @(negedge clk);
    chk("coll rbusy x3", XLEN'(rbusy[0]), 32'h1);
    chk("coll rdata x3", rdata[0], 32'h33);
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      rst_n = ($urandom_range(0, 299) != 0);
      we = NWR'($urandom);
      for (int p = 0; p < NWR; p++) begin
        waddr[p] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
        wdata[p] = $urandom;
      end
      for (int i = 0; i < NRD; i++) raddr[i] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      iss_valid = $urandom_range(0, 1) == 1;
      iss_rd = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      dbg_addr = AW'($urandom_range(0, 7));
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
